// File: rtl/rv32i_pkg.sv
// RV32I encoder shared definitions.
// Op classes, opcodes, error codes, SYSTEM selectors and field packers.
package rv32i_pkg;

    typedef enum logic [3:0] {
        OP_LUI    = 4'd0,
        OP_AUIPC  = 4'd1,
        OP_JAL    = 4'd2,
        OP_JALR   = 4'd3,
        OP_BRANCH = 4'd4,
        OP_LOAD   = 4'd5,
        OP_STORE  = 4'd6,
        OP_OPIMM  = 4'd7,
        OP_OP     = 4'd8,
        OP_CSR    = 4'd9,
        OP_SYSTEM = 4'd10,
        OP_LI     = 4'd11
    } op_e;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'b00,
        ERR_F3    = 2'b01,
        ERR_RANGE = 2'b10,
        ERR_ALIGN = 2'b11
    } err_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [31:0] SYS_ECALL  = 32'd0;
    localparam logic [31:0] SYS_EBREAK = 32'd1;
    localparam logic [31:0] SYS_MRET   = 32'd2;
    localparam logic [31:0] SYS_SRET   = 32'd3;
    localparam logic [31:0] SYS_WFI    = 32'd4;

    localparam logic [31:0] INSTR_ECALL  = 32'h00000073;
    localparam logic [31:0] INSTR_EBREAK = 32'h00100073;
    localparam logic [31:0] INSTR_MRET   = 32'h30200073;
    localparam logic [31:0] INSTR_SRET   = 32'h10200073;
    localparam logic [31:0] INSTR_WFI    = 32'h10500073;
    localparam logic [31:0] INSTR_NOP    = 32'h00000013;

    // True when the 32-bit value is representable as signed 12-bit.
    function automatic logic fits_s12(input logic [31:0] v);
        return (&v[31:11]) || (~|v[31:11]);
    endfunction

    function automatic logic [31:0] enc_i(
        input logic [11:0] imm,
        input logic [4:0]  rs1,
        input logic [2:0]  f3,
        input logic [4:0]  rd,
        input logic [6:0]  opc
    );
        return {imm, rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] enc_u(
        input logic [19:0] imm,
        input logic [4:0]  rd,
        input logic [6:0]  opc
    );
        return {imm, rd, opc};
    endfunction

endpackage

// File: rtl/instr_imm_check.sv
// Immediate range and alignment checks per op class.
// Purely combinational; the encoder decides error priority.
module instr_imm_check
    import rv32i_pkg::*;
(
    input  logic [3:0]  i_op,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_imm,
    output logic        o_misalign,
    output logic        o_range
);

    op_e  w_op;
    logic w_fits12;
    logic w_fits13;
    logic w_fits21;
    logic w_shift;

    assign w_op     = op_e'(i_op);
    assign w_fits12 = fits_s12(i_imm);
    assign w_fits13 = (&i_imm[31:12]) || (~|i_imm[31:12]);
    assign w_fits21 = (&i_imm[31:20]) || (~|i_imm[31:20]);
    assign w_shift  = (i_funct3 == 3'b001) || (i_funct3 == 3'b101);

    // Per-class legality of the immediate operand.
    always_comb begin
        o_misalign = 1'b0;
        o_range    = 1'b0;
        unique case (w_op)
            OP_LUI, OP_AUIPC: o_range = |i_imm[11:0];
            OP_JAL: begin
                o_misalign = i_imm[0];
                o_range    = !w_fits21;
            end
            OP_BRANCH: begin
                o_misalign = i_imm[0];
                o_range    = !w_fits13;
            end
            OP_JALR, OP_LOAD, OP_STORE: o_range = !w_fits12;
            OP_OPIMM: begin
                if (w_shift) o_range = |i_imm[31:5];
                else         o_range = !w_fits12;
            end
            OP_CSR: o_range = |i_imm[31:12];
            default: begin
                o_misalign = 1'b0;
                o_range    = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/instr_encode.sv
// RV32I instruction encoder with LI pseudo-op expansion.
// One registered output stage, valid/ready on both sides.
module instr_encode
    import rv32i_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [2:0]  req_funct3,
    input  logic        req_alt,
    input  logic [4:0]  req_rd,
    input  logic [4:0]  req_rs1,
    input  logic [4:0]  req_rs2,
    input  logic [31:0] req_imm,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic        err_valid,
    output logic [1:0]  err_code
);

    typedef enum logic {S_IDLE, S_EMIT2} state_e;

    state_e      r_state;
    state_e      w_state_nxt;
    logic        r_instr_valid;
    logic [31:0] r_instr;
    logic [31:0] r_second;
    logic        r_err_valid;
    err_e        r_err_code;

    op_e         w_op;
    logic        w_accept;
    logic        w_hs;
    logic        w_load2;
    logic        w_misalign;
    logic        w_range;
    logic [31:0] w_enc;
    logic [31:0] w_second;
    logic        w_two;
    err_e        w_code;
    logic [19:0] w_li_hi;
    logic        w_shift;

    assign w_op     = op_e'(req_op);
    assign w_hs     = r_instr_valid && instr_ready;
    assign w_accept = req_valid && req_ready;
    assign w_shift  = (req_funct3 == 3'b001) || (req_funct3 == 3'b101);
    // (imm + 0x800) >> 12 without an unused low sum
    assign w_li_hi  = req_imm[31:12] + {19'd0, req_imm[11]};

    assign req_ready = rst_n && r_state == S_IDLE
                     && (!r_instr_valid || instr_ready);

    assign instr_valid = r_instr_valid;
    assign instr       = r_instr;
    assign err_valid   = r_err_valid;
    assign err_code    = r_err_code;

    instr_imm_check u_imm_check (
        .i_op       (req_op),
        .i_funct3   (req_funct3),
        .i_imm      (req_imm),
        .o_misalign (w_misalign),
        .o_range    (w_range)
    );

    // Encode the request; funct3 errors beat alignment beat range.
    always_comb begin
        w_enc    = '0;
        w_second = '0;
        w_two    = 1'b0;
        w_code   = ERR_NONE;
        unique case (w_op)
            OP_LUI:   w_enc = enc_u(req_imm[31:12], req_rd, OPC_LUI);
            OP_AUIPC: w_enc = enc_u(req_imm[31:12], req_rd, OPC_AUIPC);
            OP_JAL: begin
                w_enc = {req_imm[20], req_imm[10:1], req_imm[11],
                         req_imm[19:12], req_rd, OPC_JAL};
            end
            OP_JALR: begin
                w_enc = enc_i(req_imm[11:0], req_rs1, 3'b000,
                              req_rd, OPC_JALR);
            end
            OP_BRANCH: begin
                if (req_funct3 == 3'b010 || req_funct3 == 3'b011)
                    w_code = ERR_F3;
                w_enc = {req_imm[12], req_imm[10:5], req_rs2, req_rs1,
                         req_funct3, req_imm[4:1], req_imm[11],
                         OPC_BRANCH};
            end
            OP_LOAD: begin
                if (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11)
                    w_code = ERR_F3;
                w_enc = enc_i(req_imm[11:0], req_rs1, req_funct3,
                              req_rd, OPC_LOAD);
            end
            OP_STORE: begin
                if (req_funct3 >= 3'b011)
                    w_code = ERR_F3;
                w_enc = {req_imm[11:5], req_rs2, req_rs1, req_funct3,
                         req_imm[4:0], OPC_STORE};
            end
            OP_OPIMM: begin
                if (req_alt && req_funct3 != 3'b101)
                    w_code = ERR_F3;
                if (w_shift)
                    w_enc = {1'b0, req_alt, 5'd0, req_imm[4:0], req_rs1,
                             req_funct3, req_rd, OPC_OPIMM};
                else
                    w_enc = enc_i(req_imm[11:0], req_rs1, req_funct3,
                                  req_rd, OPC_OPIMM);
            end
            OP_OP: begin
                if (req_alt && req_funct3 != 3'b000
                            && req_funct3 != 3'b101)
                    w_code = ERR_F3;
                w_enc = {1'b0, req_alt, 5'd0, req_rs2, req_rs1,
                         req_funct3, req_rd, OPC_OP};
            end
            OP_CSR: begin
                if (req_funct3[1:0] == 2'b00)
                    w_code = ERR_F3;
                w_enc = enc_i(req_imm[11:0], req_rs1, req_funct3,
                              req_rd, OPC_SYSTEM);
            end
            OP_SYSTEM: begin
                unique case (req_imm)
                    SYS_ECALL:  w_enc = INSTR_ECALL;
                    SYS_EBREAK: w_enc = INSTR_EBREAK;
                    SYS_MRET:   w_enc = INSTR_MRET;
                    SYS_SRET:   w_enc = INSTR_SRET;
                    SYS_WFI:    w_enc = INSTR_WFI;
                    default:    w_code = ERR_F3;
                endcase
            end
            OP_LI: begin
                if (fits_s12(req_imm)) begin
                    w_enc = enc_i(req_imm[11:0], 5'd0, 3'b000,
                                  req_rd, OPC_OPIMM);
                end else begin
                    w_enc    = enc_u(w_li_hi, req_rd, OPC_LUI);
                    w_second = enc_i(req_imm[11:0], req_rd, 3'b000,
                                     req_rd, OPC_OPIMM);
                    w_two    = |req_imm[11:0];
                end
            end
            default: w_code = ERR_F3;
        endcase
        if (w_code == ERR_NONE) begin
            if (w_misalign)   w_code = ERR_ALIGN;
            else if (w_range) w_code = ERR_RANGE;
        end
    end

    // State register for the LI two-beat expansion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state and second-beat load strobe.
    always_comb begin
        w_state_nxt = r_state;
        w_load2     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept && w_code == ERR_NONE && w_two)
                    w_state_nxt = S_EMIT2;
            end
            S_EMIT2: begin
                if (w_hs) begin
                    w_state_nxt = S_IDLE;
                    w_load2     = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output register: load on accept or second beat, drop on handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr_valid <= 1'b0;
            r_instr       <= INSTR_NOP;
            r_second      <= '0;
            r_err_valid   <= 1'b0;
            r_err_code    <= ERR_NONE;
        end else begin
            r_err_valid <= 1'b0;
            if (w_accept) begin
                if (w_code != ERR_NONE) begin
                    r_instr_valid <= 1'b0;
                    r_err_valid   <= 1'b1;
                    r_err_code    <= w_code;
                end else begin
                    r_instr_valid <= 1'b1;
                    r_instr       <= w_enc;
                    r_second      <= w_second;
                end
            end else if (w_load2) begin
                r_instr_valid <= 1'b1;
                r_instr       <= r_second;
            end else if (w_hs) begin
                r_instr_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instr_encode.sv
// Table-driven check of instr_encode plus stall/LI/reset sequences.
// Expected encodings are hand-computed RV32I words.
module tb_instr_encode;

    localparam logic [3:0] C_LUI = 4'd0, C_AUIPC = 4'd1, C_JAL = 4'd2;
    localparam logic [3:0] C_JALR = 4'd3, C_BR = 4'd4, C_LD = 4'd5;
    localparam logic [3:0] C_ST = 4'd6, C_OPI = 4'd7, C_OP = 4'd8;
    localparam logic [3:0] C_CSR = 4'd9, C_SYS = 4'd10, C_LI = 4'd11;

    typedef struct {
        logic [3:0]  op;
        logic [2:0]  f3;
        logic        alt;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [1:0]  code;
        logic [31:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_op = '0;
    logic [2:0]  req_funct3 = '0;
    logic        req_alt = 1'b0;
    logic [4:0]  req_rd = '0;
    logic [4:0]  req_rs1 = '0;
    logic [4:0]  req_rs2 = '0;
    logic [31:0] req_imm = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b1;
    logic [31:0] instr;
    logic        err_valid;
    logic [1:0]  err_code;

    int n_vec = 0;
    int n_bad = 0;
    vec_t vecs[$];

    instr_encode dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_funct3  (req_funct3),
        .req_alt     (req_alt),
        .req_rd      (req_rd),
        .req_rs1     (req_rs1),
        .req_rs2     (req_rs2),
        .req_imm     (req_imm),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .err_valid   (err_valid),
        .err_code    (err_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h, want %08h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic [3:0] op, input logic [2:0] f3, input logic alt,
        input logic [4:0] rd, input logic [4:0] rs1,
        input logic [4:0] rs2, input logic [31:0] imm,
        input logic [1:0] code, input logic [31:0] exp);
        vec_t v;
        v.op = op; v.f3 = f3; v.alt = alt; v.rd = rd;
        v.rs1 = rs1; v.rs2 = rs2; v.imm = imm;
        v.code = code; v.exp = exp;
        return v;
    endfunction

    task automatic drive(input logic [3:0] op, input logic [2:0] f3,
                         input logic alt, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [31:0] imm);
        req_op = op; req_funct3 = f3; req_alt = alt; req_rd = rd;
        req_rs1 = rs1; req_rs2 = rs2; req_imm = imm;
        req_valid = 1'b1;
    endtask

    task automatic li_seq(input string nm, input logic [4:0] rd,
                          input logic [31:0] imm, input logic [31:0] e1,
                          input logic [31:0] e2);
        @(negedge clk);
        instr_ready = 1'b1;
        drive(C_LI, 3'd0, 1'b0, rd, 5'd0, 5'd0, imm);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk({nm, " beat1 valid"}, {31'd0, instr_valid}, 32'd1);
        chk({nm, " beat1"}, instr, e1);
        chk({nm, " busy"}, {31'd0, req_ready}, 32'd0);
        @(posedge clk); #1;
        chk({nm, " beat2 valid"}, {31'd0, instr_valid}, 32'd1);
        chk({nm, " beat2"}, instr, e2);
        @(posedge clk); #1;
        chk({nm, " drained"}, {31'd0, instr_valid}, 32'd0);
    endtask

    initial begin
        vecs.push_back(mk(C_OPI, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF, 2'b00, 32'hFFF00093));
        vecs.push_back(mk(C_LUI, 3'd7, 1'b0, 5'd5, 5'd7, 5'd9, 32'h12345000, 2'b00, 32'h123452B7));
        vecs.push_back(mk(C_AUIPC, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'hFFFFF000, 2'b00, 32'hFFFFF097));
        vecs.push_back(mk(C_OP, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 2'b00, 32'h002081B3));
        vecs.push_back(mk(C_OP, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0, 2'b00, 32'h402081B3));
        vecs.push_back(mk(C_OPI, 3'd5, 1'b1, 5'd1, 5'd1, 5'd0, 32'd3, 2'b00, 32'h4030D093));
        vecs.push_back(mk(C_OPI, 3'd1, 1'b0, 5'd1, 5'd1, 5'd0, 32'd32, 2'b10, 32'd0));
        vecs.push_back(mk(C_OPI, 3'd0, 1'b1, 5'd1, 5'd1, 5'd0, 32'd1, 2'b01, 32'd0));
        vecs.push_back(mk(C_OP, 3'd7, 1'b1, 5'd1, 5'd1, 5'd2, 32'd0, 2'b01, 32'd0));
        vecs.push_back(mk(C_JAL, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8, 2'b00, 32'h008000EF));
        vecs.push_back(mk(C_JAL, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC, 2'b00, 32'hFFDFF06F));
        vecs.push_back(mk(C_JAL, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'h00100000, 2'b10, 32'd0));
        vecs.push_back(mk(C_JALR, 3'd0, 1'b0, 5'd1, 5'd5, 5'd0, 32'd0, 2'b00, 32'h000280E7));
        vecs.push_back(mk(C_BR, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8, 2'b00, 32'h00208463));
        vecs.push_back(mk(C_BR, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd3, 2'b11, 32'd0));
        vecs.push_back(mk(C_BR, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd4096, 2'b10, 32'd0));
        vecs.push_back(mk(C_BR, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8, 2'b01, 32'd0));
        vecs.push_back(mk(C_LD, 3'd2, 1'b0, 5'd5, 5'd2, 5'd0, 32'd16, 2'b00, 32'h01012283));
        vecs.push_back(mk(C_LD, 3'd7, 1'b0, 5'd5, 5'd2, 5'd0, 32'd16, 2'b01, 32'd0));
        vecs.push_back(mk(C_ST, 3'd2, 1'b0, 5'd0, 5'd2, 5'd5, 32'hFFFFFFF8, 2'b00, 32'hFE512C23));
        vecs.push_back(mk(C_ST, 3'd3, 1'b0, 5'd0, 5'd2, 5'd5, 32'd0, 2'b01, 32'd0));
        vecs.push_back(mk(C_CSR, 3'd1, 1'b0, 5'd1, 5'd2, 5'd0, 32'h300, 2'b00, 32'h300110F3));
        vecs.push_back(mk(C_CSR, 3'd1, 1'b0, 5'd1, 5'd2, 5'd0, 32'h1000, 2'b10, 32'd0));
        vecs.push_back(mk(C_CSR, 3'd4, 1'b0, 5'd1, 5'd2, 5'd0, 32'h300, 2'b01, 32'd0));
        vecs.push_back(mk(C_SYS, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd2, 2'b00, 32'h30200073));
        vecs.push_back(mk(C_SYS, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 2'b00, 32'h00000073));
        vecs.push_back(mk(C_SYS, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd7, 2'b01, 32'd0));
        vecs.push_back(mk(C_LI, 3'd0, 1'b0, 5'd2, 5'd0, 5'd0, 32'hFFFFFFFB, 2'b00, 32'hFFB00113));
        vecs.push_back(mk(C_LI, 3'd0, 1'b0, 5'd3, 5'd0, 5'd0, 32'h00005000, 2'b00, 32'h000051B7));

        // reset state
        #12;
        chk("rst instr_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst instr", instr, 32'h00000013);
        chk("rst req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst err_valid", {31'd0, err_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // table, back-to-back
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].op, vecs[i].f3, vecs[i].alt, vecs[i].rd,
                  vecs[i].rs1, vecs[i].rs2, vecs[i].imm);
            chk($sformatf("v%0d ready", i), {31'd0, req_ready}, 32'd1);
            @(posedge clk); #1;
            req_valid = 1'b0;
            if (vecs[i].code == 2'b00) begin
                chk($sformatf("v%0d valid", i), {31'd0, instr_valid}, 32'd1);
                chk($sformatf("v%0d instr", i), instr, vecs[i].exp);
                chk($sformatf("v%0d noerr", i), {31'd0, err_valid}, 32'd0);
            end else begin
                chk($sformatf("v%0d novalid", i), {31'd0, instr_valid}, 32'd0);
                chk($sformatf("v%0d err", i), {31'd0, err_valid}, 32'd1);
                chk($sformatf("v%0d code", i), {30'd0, err_code}, {30'd0, vecs[i].code});
            end
        end
        @(posedge clk); #1;
        chk("idle after table", {31'd0, instr_valid}, 32'd0);
        chk("err pulse ends", {31'd0, err_valid}, 32'd0);

        // LI expansions
        li_seq("li 12345678", 5'd5, 32'h12345678, 32'h123452B7, 32'h67828293);
        li_seq("li 800", 5'd1, 32'h00000800, 32'h000010B7, 32'h80008093);

        // downstream stall for 3 cycles
        @(negedge clk);
        instr_ready = 1'b0;
        drive(C_OP, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0);
        @(posedge clk); #1;
        drive(C_OP, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk($sformatf("stall%0d valid", c), {31'd0, instr_valid}, 32'd1);
            chk($sformatf("stall%0d instr", c), instr, 32'h002081B3);
            chk($sformatf("stall%0d ready", c), {31'd0, req_ready}, 32'd0);
        end
        @(negedge clk);
        instr_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("post stall valid", {31'd0, instr_valid}, 32'd1);
        chk("post stall instr", instr, 32'h402081B3);
        @(posedge clk); #1;
        chk("post stall drain", {31'd0, instr_valid}, 32'd0);

        // reset between LI beats
        @(negedge clk);
        instr_ready = 1'b0;
        drive(C_LI, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345678);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("mid li beat1", instr, 32'h123452B7);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid rst valid", {31'd0, instr_valid}, 32'd0);
        chk("mid rst instr", instr, 32'h00000013);
        chk("mid rst ready", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        instr_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            chk($sformatf("no beat2 %0d", c), {31'd0, instr_valid}, 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
